uart_cmd_rx: RTL and testbench
==============================

UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per UART bit; even value, 8 or greater.
REQ-002 Parameter CMD_WAVE, default 8'h77 ('w'), byte that requests a waveform capture.
REQ-003 Parameter CMD_FIR, default 8'h66 ('f'), byte that requests a FIR capture.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 UART_RX  input  1  asynchronous serial line; idle high; 8N1 format, LSB first.
REQ-007 char  output  8  last correctly framed byte.
REQ-008 char_valid  output  1  one-cycle pulse when char updates.
REQ-009 cmd_wave  output  1  one-cycle pulse, coincident with char_valid, when the byte equals CMD_WAVE.
REQ-010 cmd_fir  output  1  one-cycle pulse, coincident with char_valid, when the byte equals CMD_FIR.
REQ-011 frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-012 err_count  output  8  count of framing errors; saturates at 255.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 UART_RX shall pass through a 2-flop synchronizer (both flops preset to 1); all FSM decisions use the second flop output (rx_s).
REQ-015 FSM states shall be IDLE, START, DATA, STOP and BREAK.
REQ-016 IDLE: when rx_s==0, go to START and clear the bit counter cnt.
REQ-017 START: count cnt to CLKS_PER_BIT/2-1; at that count go to DATA if rx_s==0, otherwise return to IDLE (glitch rejected, no output).
REQ-018 DATA: at each cnt==CLKS_PER_BIT-1, shift rx_s into bit index 0..7 (LSB first) and clear cnt; after bit 7 go to STOP.
REQ-019 STOP: at cnt==CLKS_PER_BIT-1, if rx_s==1, load char, pulse char_valid plus any matching cmd_* pulse, and go to IDLE.
REQ-020 STOP: at cnt==CLKS_PER_BIT-1, if rx_s==0, pulse frame_err, increment err_count (saturating), leave char unchanged, and go to BREAK.
REQ-021 BREAK: stay until rx_s==1, then go to IDLE; no start detection while in BREAK.
REQ-022 Latency: char_valid is high in the cycle after edge number 3+CLKS_PER_BIT/2+9*CLKS_PER_BIT, counting the first edge that registers UART_RX low as edge 1 (edge 155 for the default).
REQ-023 All pulse outputs shall be registered, high exactly one cycle, and at most one of char_valid/frame_err per frame.
REQ-024 cmd_wave and cmd_fir shall never both assert; neither asserts with frame_err.
REQ-025 A start bit received immediately after a valid stop sample (back-to-back frames) shall be accepted with no dropped byte.
REQ-026 cnt width shall be $clog2(CLKS_PER_BIT); the bit index is 3 bits; no other arithmetic wraps.

Reset
REQ-027 While rst_n==0 at a clock edge, the block shall set state=IDLE, synchronizer flops=1, cnt=0, char=8'h00, err_count=0, and all pulses and busy to 0.
REQ-028 Reset asserted mid-frame shall abort the frame with no char_valid or frame_err; reception resumes on the next falling edge after release.
REQ-029 Reset takes priority over every other event in the same cycle.

Verification
REQ-030 Send 0x77 at CLKS_PER_BIT=16 -> char=8'h77, char_valid and cmd_wave pulse one cycle at the REQ-022 edge (155), cmd_fir stays 0.
REQ-031 Send 0x66 then 0xA5 back-to-back -> two char_valid pulses; cmd_fir on the first only; final char=8'hA5.
REQ-032 UART_RX low for 4 cycles, then high -> no outputs, busy returns to 0, FSM in IDLE.
REQ-033 Send 0x55 with stop bit low, line held low 40 cycles then high, then send 0x77 -> one frame_err pulse, err_count=1, char unchanged until 0x77 is received correctly.
REQ-034 Drive rst_n low during data bit 4 of a frame, then release -> all outputs at reset values; next full frame 0x66 is received correctly.
REQ-035 Force 256 framing errors -> err_count saturates at 8'hFF.

Source files
------------

// File: rtl/uart_cmd_rx_if.sv
// Signal bundle of the UART command receiver.
// slave: receiver side; master: line driver and observer.
interface uart_cmd_rx_if;
    logic       UART_RX;
    logic [7:0] char;
    logic       char_valid;
    logic       cmd_wave;
    logic       cmd_fir;
    logic       frame_err;
    logic [7:0] err_count;
    logic       busy;

    modport slave (
        input  UART_RX,
        output char,
        output char_valid,
        output cmd_wave,
        output cmd_fir,
        output frame_err,
        output err_count,
        output busy
    );

    modport master (
        output UART_RX,
        input  char,
        input  char_valid,
        input  cmd_wave,
        input  cmd_fir,
        input  frame_err,
        input  err_count,
        input  busy
    );
endinterface

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver that decodes single-byte commands
// and counts framing errors.
module uart_cmd_rx #(
    parameter int         CLKS_PER_BIT = 16,
    parameter logic [7:0] CMD_WAVE     = 8'h77,
    parameter logic [7:0] CMD_FIR      = 8'h66
) (
    input logic          clk,
    input logic          rst_n,
    uart_cmd_rx_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST =
        CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST =
        CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state;
    logic          sync1;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    char_q;
    logic [7:0]    err_q;
    logic          valid_q;
    logic          wave_q;
    logic          fir_q;
    logic          ferr_q;
    logic          busy_q;

    assign bus.char       = char_q;
    assign bus.char_valid = valid_q;
    assign bus.cmd_wave   = wave_q;
    assign bus.cmd_fir    = fir_q;
    assign bus.frame_err  = ferr_q;
    assign bus.err_count  = err_q;
    assign bus.busy       = busy_q;

    // Two-flop synchronizer; presets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= bus.UART_RX;
            rx_s  <= sync1;
        end
    end

    // Frame FSM: mid-bit sampling, registered pulses and busy flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            char_q  <= '0;
            err_q   <= '0;
            valid_q <= 1'b0;
            wave_q  <= 1'b0;
            fir_q   <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            wave_q  <= 1'b0;
            fir_q   <= 1'b0;
            ferr_q  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state  <= START;
                        busy_q <= 1'b1;
                        cnt    <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            char_q  <= shreg;
                            valid_q <= 1'b1;
                            wave_q  <= (shreg == CMD_WAVE);
                            fir_q   <= (shreg == CMD_FIR);
                            state   <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_q <= 1'b1;
                            if (err_q != 8'hFF) begin
                                err_q <= err_q + 1'b1;
                            end
                            state <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_rx.sv
// Randomized bench for uart_cmd_rx with a frame-level
// expectation queue and per-cycle output comparison.
`timescale 1ns/1ps
module tb_uart_cmd_rx;
    localparam int N = 16;
    localparam logic [7:0] CW_B = 8'h77;
    localparam logic [7:0] CF_B = 8'h66;
    localparam int LAT = 3 + N / 2 + 9 * N;

    typedef struct {
        int         t;
        logic [7:0] b;
        bit         ok;
    } ev_t;

    logic clk;
    logic rst_n;
    uart_cmd_rx_if bus ();

    uart_cmd_rx #(
        .CLKS_PER_BIT(N),
        .CMD_WAVE(CW_B),
        .CMD_FIR(CF_B)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    ev_t        evq[$];
    logic [7:0] m_char;
    int         m_err;
    int         n_chk;
    int         n_fail;
    int         cyc;
    int         n_valid;
    int         n_ferr;
    int         last_valid;
    int         last_start;
    logic       rst_seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the frame-level model.
    always @(posedge clk) begin
        logic ev_v;
        logic ev_e;
        ev_t  ev;
        cyc = cyc + 1;
        rst_seen = rst_n;
        #1;
        if (!rst_seen) begin
            m_char = 8'h00;
            m_err  = 0;
            evq.delete();
            chk("rst_valid", bus.char_valid, 1'b0);
            chk("rst_ferr", bus.frame_err, 1'b0);
            chk("rst_wave", bus.cmd_wave, 1'b0);
            chk("rst_fir", bus.cmd_fir, 1'b0);
            chk("rst_busy", bus.busy, 1'b0);
            chk("rst_char", bus.char, 8'h00);
            chk("rst_errcnt", bus.err_count, 8'h00);
        end else begin
            ev_v = 1'b0;
            ev_e = 1'b0;
            if (evq.size() > 0 && evq[0].t <= cyc) begin
                ev = evq.pop_front();
                if (ev.t != cyc) begin
                    chk("stale_event", ev.t, cyc);
                end else if (ev.ok) begin
                    ev_v = 1'b1;
                    m_char = ev.b;
                end else begin
                    ev_e = 1'b1;
                    m_err = (m_err >= 255) ? 255 : m_err + 1;
                end
            end
            chk("char_valid", bus.char_valid, ev_v);
            chk("frame_err", bus.frame_err, ev_e);
            chk("cmd_wave", bus.cmd_wave,
                ev_v && (m_char == CW_B));
            chk("cmd_fir", bus.cmd_fir,
                ev_v && (m_char == CF_B));
            chk("char", bus.char, m_char);
            chk("err_count", bus.err_count, m_err);
            if (bus.char_valid === 1'b1) begin
                n_valid++;
                last_valid = cyc;
            end
            if (bus.frame_err === 1'b1) n_ferr++;
        end
    end

    task automatic send_bit(input logic b);
        bus.UART_RX = b;
        repeat (N) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b,
                              input bit ok,
                              input int hold);
        ev_t ev;
        last_start = cyc;
        ev.t  = cyc + LAT;
        ev.b  = b;
        ev.ok = ok;
        evq.push_back(ev);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        if (ok) begin
            send_bit(1'b1);
        end else begin
            send_bit(1'b0);
            repeat (hold) @(negedge clk);
            bus.UART_RX = 1'b1;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        bus.UART_RX = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic glitch(input int n);
        bus.UART_RX = 1'b0;
        repeat (n) @(negedge clk);
        idle(N);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int e0;
        logic [7:0] b;
        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        n_valid = 0;
        n_ferr = 0;
        last_valid = 0;
        last_start = 0;
        m_char = 8'h00;
        m_err = 0;
        rst_n = 1'b0;
        bus.UART_RX = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        chk("post_rst_busy", bus.busy, 1'b0);
        chk("post_rst_char", bus.char, 8'h00);

        // Single 'w' frame with absolute latency pin.
        send_frame(8'h77, 1'b1, 0);
        idle(10);
        chk("lat_77", last_valid - last_start, 155);
        chk("char_77", bus.char, 8'h77);
        chk("busy_77", bus.busy, 1'b0);

        // Back-to-back 'f' then 0xA5.
        v0 = n_valid;
        send_frame(8'h66, 1'b1, 0);
        send_frame(8'hA5, 1'b1, 0);
        idle(10);
        chk("b2b_count", n_valid - v0, 2);
        chk("b2b_char", bus.char, 8'hA5);

        // Short low glitch is rejected.
        v0 = n_valid;
        e0 = n_ferr;
        glitch(4);
        chk("glitch_valid", n_valid - v0, 0);
        chk("glitch_ferr", n_ferr - e0, 0);
        chk("glitch_busy", bus.busy, 1'b0);

        // Bad stop with long break, then a good 'w'.
        send_frame(8'h55, 1'b0, 40);
        chk("ferr_cnt", bus.err_count, 8'd1);
        chk("ferr_char", bus.char, 8'hA5);
        send_frame(8'h77, 1'b1, 0);
        idle(10);
        chk("after_ferr_char", bus.char, 8'h77);

        // Reset during data bit 4 aborts the frame.
        b = 8'h3C;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        bus.UART_RX = b[4];
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        bus.UART_RX = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        chk("abort_char", bus.char, 8'h00);
        chk("abort_err", bus.err_count, 8'h00);
        chk("abort_busy", bus.busy, 1'b0);
        send_frame(8'h66, 1'b1, 0);
        idle(10);
        chk("resume_char", bus.char, 8'h66);

        // Random mix of frames, gaps and glitches.
        for (int k = 0; k < 60; k++) begin
            int sel;
            sel = $urandom_range(0, 7);
            if (sel == 0) begin
                glitch($urandom_range(1, 6));
            end else begin
                if (sel == 1) b = CW_B;
                else if (sel == 2) b = CF_B;
                else b = 8'($urandom);
                send_frame(b, $urandom_range(0, 5) != 0,
                           $urandom_range(0, 20));
            end
            idle($urandom_range(0, 1) == 0 ?
                 0 : $urandom_range(1, 20));
        end

        // Saturate the framing error counter.
        for (int k = 0; k < 260; k++) begin
            send_frame(8'($urandom), 1'b0, 0);
        end
        idle(10);
        chk("sat_err", bus.err_count, 8'hFF);
        chk("queue_drain", evq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
